// File: rtl/bist_mem_responder.sv
// bist_mem_responder
// Memory-side responder for the BIST request/acknowledge handshake. It accepts
// one write or read at a time, keeps words in an internal 2^ADR_SIZE x
// DATA_SIZE array and answers with a one-cycle ack after a fixed latency.
// Writes commit one edge after acceptance. Reads commit RD_LAT edges after
// acceptance.
// Optional feature macro: BIST_FAULT_INJ_EN. It adds a stuck-at-0 read fault
// injector, which gives the BIST comparator an error path it can detect.
module bist_mem_responder #(
   parameter int ADR_SIZE  = 4,
   parameter int DATA_SIZE = 8,
   parameter int RD_LAT    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic                 we,
   input  logic [ADR_SIZE-1:0]  adr,
   input  logic [DATA_SIZE-1:0] wdata,
   output logic                 ack,
   output logic [DATA_SIZE-1:0] rdata,
   output logic                 busy,
   output logic [7:0]           wr_cnt,
   output logic [7:0]           rd_cnt
`ifdef BIST_FAULT_INJ_EN
   ,
   input  logic                 fault_en,
   input  logic [ADR_SIZE-1:0]  fault_adr,
   input  logic [((DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1)-1:0] fault_bit
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // The counter is loaded with RD_LAT-1 so that ack rises RD_LAT edges after acceptance.
   localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

   state_t                 state_q;
   logic                   we_q;
   logic [ADR_SIZE-1:0]    adr_q;
   logic [DATA_SIZE-1:0]   wdata_q;
   logic [DATA_SIZE-1:0]   rdata_q;
   logic [DATA_SIZE-1:0]   rdata_d;
   logic                   ack_q;
   logic [7:0]             wr_cnt_q;
   logic [7:0]             rd_cnt_q;
   logic [3:0]             lat_q;
   logic                   mem_we_s;
   logic [DATA_SIZE-1:0]   fault_mask_s;
   logic [DATA_SIZE-1:0]   mem_q [2**ADR_SIZE];

   // Saturating completion counter increment: holds at 255, never wraps.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

   assign ack    = ack_q;
   assign rdata  = rdata_q;
   assign wr_cnt = wr_cnt_q;
   assign rd_cnt = rd_cnt_q;
   assign busy   = (state_q != ST_IDLE);

   // Array write happens only on the commit edge of a write, and reset on that edge discards it.
   assign mem_we_s = rst && (state_q == ST_WR) && we_q;

   // Build the stuck-at-0 mask applied to the word returned by a read.
   always_comb begin
      fault_mask_s = '0;
`ifdef BIST_FAULT_INJ_EN
      if (fault_en && (adr_q == fault_adr)) begin
         fault_mask_s[fault_bit] = 1'b1;
      end else begin
         fault_mask_s = '0;
      end
`endif
      rdata_d = mem_q[adr_q] & ~fault_mask_s;
   end

   // Storage array. It is not touched by reset, so contents survive a reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[adr_q] <= wdata_q;
      end
   end

   // Transaction FSM with registered ack, read data and completion counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         adr_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         wr_cnt_q <= 8'd0;
         rd_cnt_q <= 8'd0;
         lat_q    <= 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ack_q <= 1'b0;
               if (req) begin
                  we_q    <= we;
                  adr_q   <= adr;
                  wdata_q <= wdata;
                  if (we) begin
                     state_q <= ST_WR;
                  end else begin
                     state_q <= ST_RD;
                     lat_q   <= LAT_LOAD;
                  end
               end
            end
            ST_WR: begin
               ack_q    <= 1'b1;
               wr_cnt_q <= sat_inc(wr_cnt_q);
               state_q  <= ST_DONE;
            end
            ST_RD: begin
               if (lat_q != 4'd0) begin
                  lat_q <= lat_q - 4'd1;
               end else begin
                  rdata_q  <= rdata_d;
                  ack_q    <= 1'b1;
                  rd_cnt_q <= sat_inc(rd_cnt_q);
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               ack_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               ack_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bist_mem_responder.sv
// Self-checking bench for bist_mem_responder. Expected transaction results are
// queued when a request is driven and compared when the DUT acks.
module tb_bist_mem_responder;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] adr = '0;
   logic [DW-1:0] wdata = '0;
   logic          ack;
   logic [DW-1:0] rdata;
   logic          busy;
   logic [7:0]    wr_cnt;
   logic [7:0]    rd_cnt;
`ifdef BIST_FAULT_INJ_EN
   logic          fault_en = 1'b0;
   logic [AW-1:0] fault_adr = '0;
   logic [2:0]    fault_bit = 3'd0;
`endif

   typedef struct {
      bit         rd;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   int         wr_m = 0;
   int         rd_m = 0;
   logic [7:0] mem_m [16];

   bist_mem_responder #(.ADR_SIZE(AW), .DATA_SIZE(DW), .RD_LAT(RL)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`ifdef BIST_FAULT_INJ_EN
      , .fault_en(fault_en), .fault_adr(fault_adr), .fault_bit(fault_bit)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for idle, drive one request for one acceptance edge and queue its expected result.
   task automatic send(input bit w, input logic [3:0] a, input logic [7:0] d);
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL send_idle_timeout busy=%b required=0", busy);
      end
      req = 1'b1; we = w; adr = a; wdata = d;
      if (w) begin
         mem_m[a] = d;
         sb.push_back('{1'b0, d});
      end else begin
         sb.push_back('{1'b1, mem_m[a]});
      end
      tick();
      req = 1'b0;
   endtask

   // Count edges after acceptance until ack; -1 if it never comes.
   task automatic wait_ack(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ack === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic bump_model(input exp_t e);
      if (e.rd) begin
         if (rd_m < 255) rd_m++;
      end else begin
         if (wr_m < 255) wr_m++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({ack, busy, rdata, wr_cnt, rd_cnt} !== 26'd0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d ack=%b busy=%b rdata=%h wr=%0d rd=%0d required all 0",
                     i, ack, busy, rdata, wr_cnt, rd_cnt);
         end
      end
   endtask

   task automatic test_write_read();
      int   lat;
      exp_t e;
      send(1'b1, 4'd3, 8'hA5);
      wait_ack(lat);
      e = sb.pop_front();
      bump_model(e);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL wr_latency got=%0d required=1", lat); end
      checks++;
      if (wr_cnt !== 8'(wr_m)) begin errors++; $display("FAIL wr_cnt got=%0d required=%0d", wr_cnt, wr_m); end
      tick();
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL wr_ack_width ack=%b required=0", ack); end

      send(1'b0, 4'd3, 8'h00);
      wait_ack(lat);
      e = sb.pop_front();
      bump_model(e);
      checks++;
      if (lat !== RL) begin errors++; $display("FAIL rd_latency got=%0d required=%0d", lat, RL); end
      checks++;
      if (rdata !== e.data) begin errors++; $display("FAIL rd_data got=%h required=%h", rdata, e.data); end
      checks++;
      if (rd_cnt !== 8'(rd_m) || wr_cnt !== 8'(wr_m)) begin
         errors++;
         $display("FAIL rd_counts wr=%0d rd=%0d required wr=%0d rd=%0d", wr_cnt, rd_cnt, wr_m, rd_m);
      end
      tick();
      checks++;
      if (ack !== 1'b0 || rdata !== e.data) begin
         errors++;
         $display("FAIL rd_ack_width ack=%b rdata=%h required ack=0 rdata=%h", ack, rdata, e.data);
      end
   endtask

   // req held high throughout. Garbage is driven right after each acceptance
   // and the real next request right after each ack.
   task automatic test_held_req();
      int   ack_k[$];
      int   exp_k[4] = '{1, 5, 8, 12};
      bit   prev_busy = 1'b0;
      exp_t e;
      req = 1'b1; we = 1'b1; adr = 4'd0; wdata = 8'h11;
      mem_m[0] = 8'h11;
      sb.push_back('{1'b0, 8'h11});
      for (int k = 0; k < 14; k++) begin
         tick();
         if (ack === 1'b1) begin
            ack_k.push_back(k);
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL held_unexpected_ack k=%0d required no ack", k);
            end else begin
               e = sb.pop_front();
               bump_model(e);
               if (e.rd) begin
                  checks++;
                  if (rdata !== e.data) begin errors++; $display("FAIL held_rdata k=%0d got=%h required=%h", k, rdata, e.data); end
               end
               if (ack_k.size() >= 4) begin
                  req = 1'b0;
               end else if (e.rd) begin
                  we = 1'b1; adr = 4'd0; wdata = 8'h11;
                  sb.push_back('{1'b0, 8'h11});
               end else begin
                  we = 1'b0; adr = 4'd0; wdata = 8'h00;
                  sb.push_back('{1'b1, mem_m[0]});
               end
            end
         end else if (busy === 1'b1 && !prev_busy) begin
            if (we) begin we = 1'b0; adr = 4'd9; wdata = 8'h55; end
            else    begin we = 1'b1; adr = 4'd9; wdata = 8'h5A; end
         end
         prev_busy = busy;
      end
      req = 1'b0;
      checks++;
      if (ack_k.size() !== 4) begin errors++; $display("FAIL held_ack_count got=%0d required=4", ack_k.size()); end
      for (int i = 0; i < 4 && i < ack_k.size(); i++) begin
         checks++;
         if (ack_k[i] !== exp_k[i]) begin errors++; $display("FAIL held_ack_edge idx=%0d got=%0d required=%0d", i, ack_k[i], exp_k[i]); end
      end
      checks++;
      if (wr_cnt !== 8'(wr_m) || rd_cnt !== 8'(rd_m)) begin
         errors++;
         $display("FAIL held_counts wr=%0d rd=%0d required wr=%0d rd=%0d", wr_cnt, rd_cnt, wr_m, rd_m);
      end
      sb.delete();
   endtask

   task automatic test_reset_mid();
      int   lat;
      exp_t e;
      bit   saw_ack;
      send(1'b1, 4'd5, 8'h00);
      wait_ack(lat);
      e = sb.pop_front();
      tick();
      // Accept a write and reset on its commit edge.
      req = 1'b1; we = 1'b1; adr = 4'd5; wdata = 8'hFF;
      tick();
      req = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      wr_m = 0; rd_m = 0;
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || wr_cnt !== 8'd0) begin
         errors++;
         $display("FAIL rst_mid_wr ack=%b busy=%b wr=%0d required 0 0 0", ack, busy, wr_cnt);
      end
      saw_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); if (ack === 1'b1) saw_ack = 1'b1; end
      checks++;
      if (saw_ack) begin errors++; $display("FAIL rst_mid_wr_late_ack ack=1 required=0"); end

      send(1'b0, 4'd5, 8'h00);
      wait_ack(lat);
      e = sb.pop_front();
      bump_model(e);
      checks++;
      if (lat !== RL || rdata !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_wr_readback lat=%0d rdata=%h required lat=%0d rdata=00", lat, rdata, RL);
      end
      tick();

      // A normal read leaves rdata nonzero; then a read of adr 0 is aborted by reset.
      send(1'b0, 4'd3, 8'h00);
      wait_ack(lat);
      e = sb.pop_front();
      tick();
      req = 1'b1; we = 1'b0; adr = 4'd0;
      tick();
      req = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      wr_m = 0; rd_m = 0;
      checks++;
      if (ack !== 1'b0 || rdata !== 8'h00 || busy !== 1'b0 || rd_cnt !== 8'd0) begin
         errors++;
         $display("FAIL rst_mid_rd ack=%b rdata=%h busy=%b rd=%0d required 0 00 0 0", ack, rdata, busy, rd_cnt);
      end
      saw_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); if (ack === 1'b1) saw_ack = 1'b1; end
      checks++;
      if (saw_ack) begin errors++; $display("FAIL rst_mid_rd_late_ack ack=1 required=0"); end
   endtask

   task automatic test_saturation();
      int   lat;
      exp_t e;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      wr_m = 0; rd_m = 0;
      for (int i = 0; i < 260; i++) begin
         send(1'b1, 4'(i), 8'(i));
         wait_ack(lat);
         e = sb.pop_front();
         bump_model(e);
         if (i == 253 || i == 254) begin
            checks++;
            if (wr_cnt !== 8'(wr_m)) begin errors++; $display("FAIL sat_pre n=%0d got=%0d required=%0d", i + 1, wr_cnt, wr_m); end
         end
         tick();
      end
      checks++;
      if (wr_cnt !== 8'd255) begin errors++; $display("FAIL sat_wr_cnt got=%0d required=255", wr_cnt); end
      checks++;
      if (rd_cnt !== 8'd0) begin errors++; $display("FAIL sat_rd_cnt got=%0d required=0", rd_cnt); end
   endtask

`ifdef BIST_FAULT_INJ_EN
   task automatic test_fault();
      int   lat;
      exp_t e;
      send(1'b1, 4'd7, 8'hFF);
      wait_ack(lat);
      e = sb.pop_front();
      tick();
      fault_en = 1'b1; fault_adr = 4'd7; fault_bit = 3'd2;
      send(1'b0, 4'd7, 8'h00);
      sb[sb.size()-1].data = mem_m[7] & ~(8'h01 << 2);
      wait_ack(lat);
      e = sb.pop_front();
      checks++;
      if (rdata !== e.data) begin errors++; $display("FAIL fault_on got=%h required=%h", rdata, e.data); end
      tick();
      fault_adr = 4'd6;
      send(1'b0, 4'd7, 8'h00);
      wait_ack(lat);
      e = sb.pop_front();
      checks++;
      if (rdata !== e.data) begin errors++; $display("FAIL fault_other_adr got=%h required=%h", rdata, e.data); end
      tick();
      fault_en = 1'b0; fault_adr = 4'd7;
      send(1'b0, 4'd7, 8'h00);
      wait_ack(lat);
      e = sb.pop_front();
      checks++;
      if (rdata !== e.data) begin errors++; $display("FAIL fault_off got=%h required=%h", rdata, e.data); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_held_req();
      test_reset_mid();
      test_saturation();
`ifdef BIST_FAULT_INJ_EN
      test_fault();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
